// File: rtl/parking_gate_sequencer.sv
// Gate-side front end: synchronises and debounces the entry/exit beams, queues one pending
// event per channel and hands them to the parking FSM one request at a time.
module parking_gate_sequencer #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned GAP         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_beam,
  input  logic       exit_beam,
  input  logic [1:0] exit_slot_sw,
  input  logic       door_open,
  input  logic       full_light,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exit_location,
  output logic       entry_rejected,
  output logic       entry_timeout,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW  = $clog2(GAP + 1);

  localparam logic [DbW-1:0]   DbMax    = DbW'(DEBOUNCE);
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(ACK_TIMEOUT - 1);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StExitReq,
    StEntryReq,
    StEntryWait,
    StGap
  } state_e;

  // Channel index 0 is the entry beam, 1 is the exit beam.
  logic [1:0]     beam_meta_q, beam_sync_q;
  logic [1:0]     slot_meta_q, slot_sync_q;
  logic [1:0]     deb_q, deb_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  logic [1:0]     rise;

  logic           entry_pend_q, entry_pend_d;
  logic           exit_pend_q, exit_pend_d;
  logic [1:0]     slot_q, slot_d;
  logic           ovr;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             clr_entry, clr_exit, reject, timeout;

  // Debounce: count mismatching samples, accept the new level once the count hits DEBOUNCE.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      rise[i]     = 1'b0;
      if (beam_sync_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbMax) begin
        deb_d[i]    = beam_sync_q[i];
        db_cnt_d[i] = '0;
        rise[i]     = beam_sync_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    clr_entry = 1'b0;
    clr_exit  = 1'b0;
    reject    = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      StIdle: begin
        if (exit_pend_q) begin
          state_d = StExitReq;
        end else if (entry_pend_q) begin
          if (full_light) begin
            reject    = 1'b1;
            clr_entry = 1'b1;
          end else begin
            state_d = StEntryReq;
          end
        end
      end
      StExitReq: begin
        clr_exit = 1'b1;
        gap_d    = GapLoad;
        state_d  = StGap;
      end
      StEntryReq: begin
        clr_entry = 1'b1;
        wait_d    = WaitLoad;
        state_d   = StEntryWait;
      end
      StEntryWait: begin
        // door_open takes precedence over a timeout expiring in the same cycle.
        if (door_open) begin
          gap_d   = GapLoad;
          state_d = StGap;
        end else if (wait_q == '0) begin
          timeout = 1'b1;
          gap_d   = GapLoad;
          state_d = StGap;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A flag consumed this cycle is free again for a coincident new edge.
  always_comb begin
    entry_pend_d = entry_pend_q & ~clr_entry;
    exit_pend_d  = exit_pend_q & ~clr_exit;
    slot_d       = slot_q;
    ovr          = 1'b0;
    if (rise[0]) begin
      if (entry_pend_d) begin
        ovr = 1'b1;
      end else begin
        entry_pend_d = 1'b1;
      end
    end
    if (rise[1]) begin
      if (exit_pend_d) begin
        ovr = 1'b1;
      end else begin
        exit_pend_d = 1'b1;
        slot_d      = slot_sync_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beam_meta_q  <= '0;
      beam_sync_q  <= '0;
      slot_meta_q  <= '0;
      slot_sync_q  <= '0;
      deb_q        <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      slot_q       <= '0;
      state_q      <= StIdle;
      wait_q       <= '0;
      gap_q        <= '0;
    end else begin
      beam_meta_q  <= {exit_beam, entry_beam};
      beam_sync_q  <= beam_meta_q;
      slot_meta_q  <= exit_slot_sw;
      slot_sync_q  <= slot_meta_q;
      deb_q        <= deb_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      slot_q       <= slot_d;
      state_q      <= state_d;
      wait_q       <= wait_d;
      gap_q        <= gap_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_sensor   <= 1'b0;
      exit_sensor    <= 1'b0;
      exit_location  <= 2'b00;
      entry_rejected <= 1'b0;
      entry_timeout  <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      entry_sensor   <= (state_d == StEntryReq);
      exit_sensor    <= (state_d == StExitReq);
      if (state_d == StExitReq) exit_location <= slot_q;
      entry_rejected <= reject;
      entry_timeout  <= timeout;
      overrun        <= ovr;
      busy           <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Bench for parking_gate_sequencer: table of directed scenarios, a reset-mid-wait sequence and a
// randomized run checked against a timestamp-based reference model.
module tb_parking_gate_sequencer;

  localparam int DEB = 4;
  localparam int ACK = 8;
  localparam int GP  = 2;
  localparam int NRAND = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_beam, exit_beam, door_open, full_light;
  logic [1:0] exit_slot_sw;
  logic       entry_sensor, exit_sensor, entry_rejected, entry_timeout, overrun, busy;
  logic [1:0] exit_location;

  int tests = 0;
  int fails = 0;

  parking_gate_sequencer #(.DEBOUNCE(DEB), .ACK_TIMEOUT(ACK), .GAP(GP)) dut (
    .clk            (clk),
    .reset          (reset),
    .entry_beam     (entry_beam),
    .exit_beam      (exit_beam),
    .exit_slot_sw   (exit_slot_sw),
    .door_open      (door_open),
    .full_light     (full_light),
    .entry_sensor   (entry_sensor),
    .exit_sensor    (exit_sensor),
    .exit_location  (exit_location),
    .entry_rejected (entry_rejected),
    .entry_timeout  (entry_timeout),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [7:0] outs();
    return {entry_sensor, exit_sensor, exit_location, entry_rejected, entry_timeout, overrun, busy};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i < b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b(input int a);
    return rng(a, a + 1);
  endfunction

  task automatic apply_reset();
    reset        = 1'b0;
    entry_beam   = 1'b0;
    exit_beam    = 1'b0;
    exit_slot_sw = 2'b00;
    door_open    = 1'b0;
    full_light   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'(outs()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed scenario table ----------------
  // Bit e of an input mask is the value presented to edge e (edge 0 is the first after reset).
  // Bit e of an expected mask is the output value in the cycle following edge e.
  typedef struct {
    logic [63:0] ent_raw;
    logic [63:0] ext_raw;
    logic [1:0]  slot;
    logic [63:0] full;
    logic [63:0] door;
    logic [63:0] x_ent;
    logic [63:0] x_ext;
    logic [63:0] x_rej;
    logic [63:0] x_tmo;
    logic [63:0] x_ovr;
    logic [63:0] x_busy;
    logic [1:0]  x_loc;
  } scn_t;

  scn_t tbl [9];

  task automatic run_scn(input int idx, input scn_t s);
    logic [63:0] a_ent, a_ext, a_rej, a_tmo, a_ovr, a_busy;
    a_ent = '0; a_ext = '0; a_rej = '0; a_tmo = '0; a_ovr = '0; a_busy = '0;
    apply_reset();
    for (int e = 0; e < 64; e++) begin
      entry_beam   = s.ent_raw[e];
      exit_beam    = s.ext_raw[e];
      exit_slot_sw = s.slot;
      full_light   = s.full[e];
      door_open    = s.door[e];
      @(posedge clk);
      #1;
      a_ent[e]  = entry_sensor;
      a_ext[e]  = exit_sensor;
      a_rej[e]  = entry_rejected;
      a_tmo[e]  = entry_timeout;
      a_ovr[e]  = overrun;
      a_busy[e] = busy;
    end
    check($sformatf("scn%0d entry_sensor", idx), a_ent, s.x_ent);
    check($sformatf("scn%0d exit_sensor", idx), a_ext, s.x_ext);
    check($sformatf("scn%0d entry_rejected", idx), a_rej, s.x_rej);
    check($sformatf("scn%0d entry_timeout", idx), a_tmo, s.x_tmo);
    check($sformatf("scn%0d overrun", idx), a_ovr, s.x_ovr);
    check($sformatf("scn%0d busy", idx), a_busy, s.x_busy);
    check($sformatf("scn%0d exit_location", idx), 64'(exit_location), 64'(s.x_loc));
  endtask

  // ---------------- reference model ----------------
  // Raw inputs reach the debouncer two edges late; a level is accepted after DEB+1 consecutive
  // disagreeing samples. The controller is tracked with timestamps: when the next dispatch is
  // allowed, the last busy cycle, and the edge window in which door_open is watched.
  logic       q_e[$], q_x[$];
  logic [1:0] q_s[$];
  logic       m_deb_e, m_deb_x, m_pe, m_px, m_waiting;
  int         m_run_e, m_run_x;
  logic [1:0] m_slot, m_loc;
  int         m_k, m_next, m_busy_thr, m_wait_first, m_clr_e_at, m_clr_x_at;

  task automatic model_reset();
    q_e.delete(); q_x.delete(); q_s.delete();
    repeat (2) begin
      q_e.push_back(1'b0);
      q_x.push_back(1'b0);
      q_s.push_back(2'b00);
    end
    m_deb_e = 1'b0; m_deb_x = 1'b0; m_pe = 1'b0; m_px = 1'b0; m_waiting = 1'b0;
    m_run_e = 0; m_run_x = 0; m_slot = 2'b00; m_loc = 2'b00;
    m_k = 0; m_next = 0; m_busy_thr = -1; m_wait_first = 0;
    m_clr_e_at = -1; m_clr_x_at = -1;
  endtask

  task automatic deb_step(input logic s, inout logic deb, inout int run, output logic rise);
    rise = 1'b0;
    if (s !== deb) begin
      run++;
      if (run == DEB + 1) begin
        deb  = s;
        run  = 0;
        rise = s;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_step(output logic [7:0] exp);
    logic se, sx, re, rx, e_s, x_s, rej, tmo, ovr, ce, cx, bz;
    logic [1:0] ss;
    e_s = 1'b0; x_s = 1'b0; rej = 1'b0; tmo = 1'b0; ovr = 1'b0;
    se = q_e.pop_front(); q_e.push_back(entry_beam);
    sx = q_x.pop_front(); q_x.push_back(exit_beam);
    ss = q_s.pop_front(); q_s.push_back(exit_slot_sw);
    deb_step(se, m_deb_e, m_run_e, re);
    deb_step(sx, m_deb_x, m_run_x, rx);
    ce = (m_clr_e_at == m_k);
    cx = (m_clr_x_at == m_k);
    if (!m_waiting && m_k >= m_next) begin
      if (m_px) begin
        x_s        = 1'b1;
        m_loc      = m_slot;
        m_clr_x_at = m_k + 1;
        m_busy_thr = m_k + GP;
        m_next     = m_k + GP + 2;
      end else if (m_pe) begin
        if (full_light) begin
          rej = 1'b1;
          ce  = 1'b1;
        end else begin
          e_s          = 1'b1;
          m_clr_e_at   = m_k + 1;
          m_waiting    = 1'b1;
          m_wait_first = m_k + 2;
          m_busy_thr   = 1 << 30;
        end
      end
    end else if (m_waiting && m_k >= m_wait_first) begin
      if (door_open || m_k == m_wait_first + ACK - 1) begin
        tmo        = !door_open;
        m_waiting  = 1'b0;
        m_busy_thr = m_k + GP - 1;
        m_next     = m_k + GP + 1;
      end
    end
    if (ce) m_pe = 1'b0;
    if (cx) m_px = 1'b0;
    if (re) begin
      if (m_pe) ovr = 1'b1;
      else m_pe = 1'b1;
    end
    if (rx) begin
      if (m_px) begin
        ovr = 1'b1;
      end else begin
        m_px   = 1'b1;
        m_slot = ss;
      end
    end
    bz  = (m_k <= m_busy_thr);
    exp = {e_s, x_s, m_loc, rej, tmo, ovr, bz};
    m_k++;
  endtask

  task automatic rand_run();
    logic [7:0] exp;
    int nfail_local;
    nfail_local = 0;
    apply_reset();
    model_reset();
    for (int e = 0; e < NRAND; e++) begin
      if ($urandom_range(0, 9) == 0) entry_beam = ~entry_beam;
      if ($urandom_range(0, 9) == 0) exit_beam = ~exit_beam;
      if ($urandom_range(0, 7) == 0) exit_slot_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) full_light = ~full_light;
      door_open = ($urandom_range(0, 5) == 0);
      model_step(exp);
      @(posedge clk);
      #1;
      if (outs() !== exp) nfail_local++;
      check($sformatf("rand edge %0d outputs", e), 64'(outs()), 64'(exp));
      if (nfail_local >= 10) break;
    end
  endtask

  task automatic reset_mid_wait();
    logic [7:0] acc;
    apply_reset();
    entry_beam = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("midwait busy before reset", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midwait async reset outputs", 64'(outs()), 64'd0);
    entry_beam = 1'b0;
    @(posedge clk);
    #1;
    check("midwait held reset outputs", 64'(outs()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    acc = '0;
    repeat (30) begin
      @(posedge clk);
      #1;
      acc |= outs();
    end
    check("midwait quiet after release", 64'(acc), 64'd0);
  endtask

  initial begin
    // single entry, door_open two cycles after the request
    tbl[0] = '{ent_raw: rng(0, 64), ext_raw: '0, slot: 2'd0, full: '0, door: b(9),
               x_ent: b(7), x_ext: '0, x_rej: '0, x_tmo: '0, x_ovr: '0,
               x_busy: rng(7, 11), x_loc: 2'd0};
    // 3-cycle exit glitch
    tbl[1] = '{ent_raw: '0, ext_raw: rng(0, 3), slot: 2'd3, full: '0, door: '0,
               x_ent: '0, x_ext: '0, x_rej: '0, x_tmo: '0, x_ovr: '0,
               x_busy: '0, x_loc: 2'd0};
    // shortest accepted exit pulse
    tbl[2] = '{ent_raw: '0, ext_raw: rng(0, 5), slot: 2'd3, full: '0, door: '0,
               x_ent: '0, x_ext: b(7), x_rej: '0, x_tmo: '0, x_ovr: '0,
               x_busy: rng(7, 10), x_loc: 2'd3};
    // simultaneous entry+exit, lot full until the exit has been served
    tbl[3] = '{ent_raw: rng(0, 64), ext_raw: rng(0, 64), slot: 2'd2, full: rng(0, 9),
               door: b(13), x_ent: b(11), x_ext: b(7), x_rej: '0, x_tmo: '0, x_ovr: '0,
               x_busy: rng(7, 10) | rng(11, 15), x_loc: 2'd2};
    // lot full
    tbl[4] = '{ent_raw: rng(0, 64), ext_raw: '0, slot: 2'd0, full: rng(0, 64), door: '0,
               x_ent: '0, x_ext: '0, x_rej: b(7), x_tmo: '0, x_ovr: '0,
               x_busy: '0, x_loc: 2'd0};
    // timeout
    tbl[5] = '{ent_raw: rng(0, 64), ext_raw: '0, slot: 2'd0, full: '0, door: '0,
               x_ent: b(7), x_ext: '0, x_rej: '0, x_tmo: b(16), x_ovr: '0,
               x_busy: rng(7, 18), x_loc: 2'd0};
    // door_open on the last wait cycle beats the timeout
    tbl[6] = '{ent_raw: rng(0, 64), ext_raw: '0, slot: 2'd0, full: '0, door: b(16),
               x_ent: b(7), x_ext: '0, x_rej: '0, x_tmo: '0, x_ovr: '0,
               x_busy: rng(7, 18), x_loc: 2'd0};
    // door_open during the request cycle is ignored
    tbl[7] = '{ent_raw: rng(0, 64), ext_raw: '0, slot: 2'd0, full: '0, door: b(8),
               x_ent: b(7), x_ext: '0, x_rej: '0, x_tmo: b(16), x_ovr: '0,
               x_busy: rng(7, 18), x_loc: 2'd0};
    // three entry events and two exits; the third entry finds the second still pending
    tbl[8] = '{ent_raw: rng(0, 5) | rng(10, 15) | rng(20, 25), ext_raw: rng(0, 5) | rng(10, 15),
               slot: 2'd1, full: '0, door: '0,
               x_ent: b(11) | b(27), x_ext: b(7) | b(23), x_rej: '0, x_tmo: b(20) | b(36),
               x_ovr: b(26), x_busy: rng(7, 10) | rng(11, 22) | rng(23, 26) | rng(27, 38),
               x_loc: 2'd1};

    for (int i = 0; i < 9; i++) run_scn(i, tbl[i]);
    reset_mid_wait();
    rand_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
